// File: rtl/nes_clk_reset_gen.sv
// nes_clk_reset_gen: holds the NES core in reset until the PLL lock is stable, then
// emits the registered PPU/CPU clock enables and phi2, phase-aligned to the sys_rst_n rise.
module nes_clk_reset_gen #(
    parameter int unsigned RESET_CYCLES = 1024,
    parameter int unsigned PPU_DIV      = 4,
    parameter int unsigned CPU_DIV      = 12
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pll_locked,
    output logic sys_rst_n,
    output logic ppu_ce,
    output logic cpu_ce,
    output logic cpu_phi2,
    output logic lock_lost
);
    localparam int unsigned CW = $clog2(RESET_CYCLES + 1);
    localparam int unsigned PW = $clog2(CPU_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(RESET_CYCLES - 1);
    localparam logic [PW-1:0] PPU_M = PW'(PPU_DIV);
    localparam logic [PW-1:0] PPU_L = PW'(PPU_DIV - 1);
    localparam logic [PW-1:0] CPU_L = PW'(CPU_DIV - 1);
    localparam logic [PW-1:0] CPU_H = PW'(CPU_DIV / 2);

    typedef enum logic [1:0] {WAIT_LOCK, STRETCH, RUN} state_t;

    state_t        state_q;
    logic [1:0]    rst_sync_q;
    logic [1:0]    lock_sync_q;
    logic [CW-1:0] cnt_q;
    logic [PW-1:0] ph_q;
    logic [PW-1:0] ph_d;
    logic          sys_rst_n_q;
    logic          ppu_ce_q;
    logic          cpu_ce_q;
    logic          cpu_phi2_q;
    logic          lock_lost_q;
    logic          locked_s;

    assign locked_s = lock_sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    // Lock synchronizer is held clear until the reset synchronizer has released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lock_sync_q <= 2'b00;
        else        lock_sync_q <= rst_sync_q[1] ? {lock_sync_q[0], pll_locked} : 2'b00;
    end

    always_comb ph_d = (ph_q == CPU_L) ? '0 : ph_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT_LOCK;
            cnt_q       <= '0;
            ph_q        <= '0;
            sys_rst_n_q <= 1'b0;
            ppu_ce_q    <= 1'b0;
            cpu_ce_q    <= 1'b0;
            cpu_phi2_q  <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    cnt_q <= '0;
                    if (locked_s) state_q <= STRETCH;
                end
                STRETCH: begin
                    if (!locked_s) begin
                        state_q <= WAIT_LOCK;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q     <= RUN;
                        ph_q        <= '0;
                        sys_rst_n_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    if (!locked_s) begin
                        state_q     <= WAIT_LOCK;
                        cnt_q       <= '0;
                        ph_q        <= '0;
                        sys_rst_n_q <= 1'b0;
                        ppu_ce_q    <= 1'b0;
                        cpu_ce_q    <= 1'b0;
                        cpu_phi2_q  <= 1'b0;
                        lock_lost_q <= 1'b1;
                    end else begin
                        ph_q       <= ph_d;
                        ppu_ce_q   <= (ph_d % PPU_M) == PPU_L;
                        cpu_ce_q   <= ph_d == CPU_L;
                        cpu_phi2_q <= ph_d >= CPU_H;
                    end
                end
                default: state_q <= WAIT_LOCK;
            endcase
        end
    end

    assign sys_rst_n = sys_rst_n_q;
    assign ppu_ce    = ppu_ce_q;
    assign cpu_ce    = cpu_ce_q;
    assign cpu_phi2  = cpu_phi2_q;
    assign lock_lost = lock_lost_q;
endmodule

// File: tb/tb_nes_clk_reset_gen.sv
// tb_nes_clk_reset_gen: default and minimal-parameter instances driven with the same lock
// waveform; expectations derive from the length of the unbroken run of high lock samples.
module tb_nes_clk_reset_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic pll_locked = 1'b0;
    logic a_sys, a_ppu, a_cpu, a_phi2, a_lost;
    logic b_sys, b_ppu, b_cpu, b_phi2, b_lost;

    always #5 clk = ~clk;

    nes_clk_reset_gen dut_a (
        .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked),
        .sys_rst_n(a_sys), .ppu_ce(a_ppu), .cpu_ce(a_cpu), .cpu_phi2(a_phi2), .lock_lost(a_lost)
    );

    nes_clk_reset_gen #(.RESET_CYCLES(1), .PPU_DIV(2), .CPU_DIV(6)) dut_b (
        .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked),
        .sys_rst_n(b_sys), .ppu_ce(b_ppu), .cpu_ce(b_cpu), .cpu_phi2(b_phi2), .lock_lost(b_lost)
    );

    typedef struct {
        int         due;
        logic [4:0] a;
        logic [4:0] b;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   edge_i = 0;
    int   streak = 0;
    logic prev_a = 1'b0, prev_b = 1'b0, lost_a = 1'b0, lost_b = 1'b0;

    task automatic check(input string tag, input logic obs, input logic exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s edge=%0d got=%b want=%b", tag, edge_i, obs, exp);
        end
    endtask

    // {sys_rst_n, ppu_ce, cpu_ce, cpu_phi2} after s consecutive high lock samples
    function automatic logic [3:0] model(input int s, input int rc, input int pd, input int cd);
        int n;
        if (s < rc + 1) return 4'b0000;
        n = s - rc - 1;
        return {1'b1, (n % pd) == pd - 1, (n % cd) == cd - 1, (n % cd) >= cd / 2};
    endfunction

    task automatic compare(input exp_t x);
        check("a.sys",  a_sys,  x.a[4]);
        check("a.ppu",  a_ppu,  x.a[3]);
        check("a.cpu",  a_cpu,  x.a[2]);
        check("a.phi2", a_phi2, x.a[1]);
        check("a.lost", a_lost, x.a[0]);
        check("b.sys",  b_sys,  x.b[4]);
        check("b.ppu",  b_ppu,  x.b[3]);
        check("b.cpu",  b_cpu,  x.b[2]);
        check("b.phi2", b_phi2, x.b[1]);
        check("b.lost", b_lost, x.b[0]);
    endtask

    // Called at a falling edge: drives the lock level for the next rising edge.
    task automatic drive(input logic v);
        logic [3:0] ma, mb;
        exp_t       x;
        pll_locked = v;
        if (edge_i >= 2) streak = v ? streak + 1 : 0;
        ma = model(streak, 1024, 4, 12);
        mb = model(streak, 1, 2, 6);
        if (prev_a && !ma[3]) lost_a = 1'b1;
        if (prev_b && !mb[3]) lost_b = 1'b1;
        prev_a = ma[3];
        prev_b = mb[3];
        sb.push_back('{edge_i + 2, {ma, lost_a}, {mb, lost_b}});
        @(posedge clk);
        #1;
        x = sb.pop_front();
        compare(x);
        edge_i++;
        @(negedge clk);
    endtask

    // Asserts rst_n between clock edges and releases it at the following falling edge.
    task automatic do_reset(input logic lock);
        rst_n = 1'b0;
        pll_locked = lock;
        #1;
        compare('{0, 5'b0, 5'b0});
        sb.delete();
        edge_i = 0;
        streak = 0;
        prev_a = 1'b0;
        prev_b = 1'b0;
        lost_a = 1'b0;
        lost_b = 1'b0;
        sb.push_back('{0, 5'b0, 5'b0});
        sb.push_back('{1, 5'b0, 5'b0});
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        do_reset(1'b1);
        repeat (1100) drive(1'b1);
        repeat (10) drive(1'b0);
        repeat (1100) drive(1'b1);
        repeat (5) drive(1'b0);
        repeat (802) drive(1'b1);
        repeat (4) drive(1'b0);
        repeat (1100) drive(1'b1);
        do_reset(1'b1);
        repeat (1100) drive(1'b1);
        do_reset(1'b0);
        repeat (500) drive(1'b0);
        repeat (1100) drive(1'b1);
        repeat (3) drive(1'b0);
        repeat (40) drive(1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
